// File: rtl/square_position_gen_if.sv
// square_position_gen_if
//   Groups the frame-tick, control and button inputs of square_position_gen
//   together with the published snapshot it produces.
//   master : drives refresh_tick, start, status and the buttons; reads the outputs
//   slave  : square_position_gen itself
//   Signals:
//     refresh_tick  frame tick (rising edge is the event)
//     start         one-cycle pulse, (re)initialise and play
//     status        1 = game over (from game_status)
//     btn_*         level-sensitive controls
//     position      660-bit packed snapshot (main square + 16 slots)
//     active_mask   bit i = slot i moving
//     busy          frame update in progress
//     overrun       sticky, tick seen while busy
interface square_position_gen_if;
  logic         refresh_tick;
  logic         start;
  logic         status;
  logic         btn_up;
  logic         btn_down;
  logic         btn_left;
  logic         btn_right;
  logic [659:0] position;
  logic [15:0]  active_mask;
  logic         busy;
  logic         overrun;

  modport master (
    output refresh_tick, start, status, btn_up, btn_down, btn_left, btn_right,
    input  position, active_mask, busy, overrun
  );

  modport slave (
    input  refresh_tick, start, status, btn_up, btn_down, btn_left, btn_right,
    output position, active_mask, busy, overrun
  );
endinterface

// File: rtl/square_position_gen.sv
// square_position_gen
//   Owns the player square and 16 obstacle slots, advances them once per frame
//   on a refresh_tick rising edge (one entity per cycle: main, then slots 0..15)
//   and publishes the new frame as one coherent snapshot on the last cycle.
//   Freezes in OVER when status reports game over at a tick; start reinitialises.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-low
//     bus    square_position_gen_if.slave (ticks, control, buttons, outputs)
//   Build option:
//     SQ_RANDOM_SPAWN_EN  spawn x/direction from a free-running 16-bit LFSR
//                         (seed ACE1h) instead of x_l = 40*slot, down-right.
module square_position_gen #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int SQ_SIZE      = 16,
  parameter int MAIN_SIZE    = 20,
  parameter int SPEED        = 2,
  parameter int MAIN_SPEED   = 4,
  parameter int SPAWN_FRAMES = 60,
  parameter int MAIN_X0      = 310,
  parameter int MAIN_Y0      = 230
) (
  input  logic                 clk,
  input  logic                 reset,
  square_position_gen_if.slave bus
);
  localparam logic [9:0] LIM_X  = 10'(SCREEN_W - SQ_SIZE);
  localparam logic [9:0] LIM_Y  = 10'(SCREEN_H - SQ_SIZE);
  localparam logic [9:0] MLIM_X = 10'(SCREEN_W - MAIN_SIZE);
  localparam logic [9:0] MLIM_Y = 10'(SCREEN_H - MAIN_SIZE);
  localparam logic [9:0] PARK   = 10'h3FF;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_UPDATE, S_OVER} state_t;

  state_t       r_state;
  logic [4:0]   r_idx;
  logic         r_tick_d1, r_tick_d2;
  logic [7:0]   r_frame_cnt;
  logic [659:0] r_position;
  logic [15:0]  r_mask;
  logic         r_busy, r_overrun;

  // Shadow frame state (not reset; always rebuilt by start before use)
  logic [9:0]   r_mx, r_my;
  logic [9:0]   r_sx [16];
  logic [9:0]   r_sy [16];
  logic [15:0]  r_dx, r_dy;

  // Obstacle step: {flip, new coord}. A square that lands on a wall turns
  // around in that same frame, so it never sits on the wall for two frames.
  function automatic logic [10:0] step_axis(input logic [9:0] c, input logic d,
                                            input logic [9:0] lim);
    logic [10:0] up;
    up = {1'b0, c} + 11'(SPEED);
    if (d) begin
      if (up >= {1'b0, lim}) step_axis = {1'b1, lim};
      else                   step_axis = {1'b0, up[9:0]};
    end else begin
      if (c <= 10'(SPEED))   step_axis = {1'b1, 10'd0};
      else                   step_axis = {1'b0, c - 10'(SPEED)};
    end
  endfunction

  // Player step with saturation to [0, lim]; opposing buttons cancel.
  function automatic logic [9:0] step_main(input logic [9:0] c, input logic inc,
                                           input logic dec, input logic [9:0] lim);
    logic [10:0] up;
    up = {1'b0, c} + 11'(MAIN_SPEED);
    step_main = c;
    if (inc && !dec)      step_main = (up > {1'b0, lim}) ? lim : up[9:0];
    else if (dec && !inc) step_main = (c < 10'(MAIN_SPEED)) ? 10'd0 : c - 10'(MAIN_SPEED);
  endfunction

  function automatic logic [39:0] pack_slot(input logic [9:0] x, input logic [9:0] y,
                                            input logic act);
    if (act) pack_slot = {y + 10'(SQ_SIZE - 1), x + 10'(SQ_SIZE - 1), y, x};
    else     pack_slot = {40{1'b1}};
  endfunction

  logic         w_tick_edge, w_main_cyc, w_obs_cyc, w_commit, w_spawn;
  logic [3:0]   w_slot, w_spawn_idx, w_sp_sel;
  logic [10:0]  w_ox, w_oy;
  logic [9:0]   w_mx, w_my, w_spawn_x;
  logic         w_spawn_dx, w_spawn_dy;
  logic [9:0]   w_nsx [16];
  logic [9:0]   w_nsy [16];
  logic [15:0]  w_nmask;
  logic [659:0] w_commit_pos, w_init_pos;

  assign w_tick_edge = r_tick_d1 & ~r_tick_d2;
  assign w_main_cyc  = (r_state == S_UPDATE) && (r_idx == 5'd0);
  assign w_obs_cyc   = (r_state == S_UPDATE) && (r_idx != 5'd0);
  assign w_commit    = (r_state == S_UPDATE) && (r_idx == 5'd16);
  assign w_slot      = 4'(r_idx - 5'd1);
  assign w_ox        = step_axis(r_sx[w_slot], r_dx[w_slot], LIM_X);
  assign w_oy        = step_axis(r_sy[w_slot], r_dy[w_slot], LIM_Y);
  assign w_mx        = step_main(r_mx, bus.btn_right, bus.btn_left, MLIM_X);
  assign w_my        = step_main(r_my, bus.btn_down, bus.btn_up, MLIM_Y);
  assign w_spawn     = w_commit && (r_frame_cnt == 8'(SPAWN_FRAMES - 1)) && (r_mask != 16'hFFFF);
  // Reinit always places slot 0; otherwise the spawn point is for the new slot.
  assign w_sp_sel    = bus.start ? 4'd0 : w_spawn_idx;

`ifdef SQ_RANDOM_SPAWN_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_spawn_x  = 10'(r_lfsr % 16'(SCREEN_W - SQ_SIZE + 1));
  assign w_spawn_dx = r_lfsr[10];
  assign w_spawn_dy = r_lfsr[11];
`else
  assign w_spawn_x  = 10'(w_sp_sel) * 10'd40;
  assign w_spawn_dx = 1'b1;
  assign w_spawn_dy = 1'b1;
`endif

  always_comb begin
    w_spawn_idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (!r_mask[i]) w_spawn_idx = 4'(i);
  end

  // Next shadow contents: current slot moved (if active), spawn applied at commit.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      w_nsx[i] = r_sx[i];
      w_nsy[i] = r_sy[i];
    end
    if (w_obs_cyc && r_mask[w_slot]) begin
      w_nsx[w_slot] = w_ox[9:0];
      w_nsy[w_slot] = w_oy[9:0];
    end
    w_nmask = r_mask;
    if (w_spawn) begin
      w_nsx[w_spawn_idx]   = w_spawn_x;
      w_nsy[w_spawn_idx]   = 10'd0;
      w_nmask[w_spawn_idx] = 1'b1;
    end
    w_commit_pos = {r_my, r_mx, 640'd0};
    for (int i = 0; i < 16; i++)
      w_commit_pos[i*40 +: 40] = pack_slot(w_nsx[i], w_nsy[i], w_nmask[i]);
    w_init_pos = {10'(MAIN_Y0), 10'(MAIN_X0), {600{1'b1}}, pack_slot(w_spawn_x, 10'd0, 1'b1)};
  end

  always_ff @(posedge clk) begin
    if (bus.start) begin
      r_mx <= 10'(MAIN_X0);
      r_my <= 10'(MAIN_Y0);
      for (int i = 0; i < 16; i++) begin
        r_sx[i] <= PARK;
        r_sy[i] <= PARK;
      end
      r_sx[0] <= w_spawn_x;
      r_sy[0] <= 10'd0;
      r_dx    <= {15'd0, w_spawn_dx};
      r_dy    <= {15'd0, w_spawn_dy};
    end else if (w_main_cyc) begin
      r_mx <= w_mx;
      r_my <= w_my;
    end else if (w_obs_cyc) begin
      for (int i = 0; i < 16; i++) begin
        r_sx[i] <= w_nsx[i];
        r_sy[i] <= w_nsy[i];
      end
      r_dx[w_slot] <= r_dx[w_slot] ^ (r_mask[w_slot] & w_ox[10]);
      r_dy[w_slot] <= r_dy[w_slot] ^ (r_mask[w_slot] & w_oy[10]);
      if (w_spawn) begin
        r_dx[w_spawn_idx] <= w_spawn_dx;
        r_dy[w_spawn_idx] <= w_spawn_dy;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_idx       <= 5'd0;
      r_tick_d1   <= 1'b0;
      r_tick_d2   <= 1'b0;
      r_frame_cnt <= 8'd0;
      r_position  <= {10'(MAIN_Y0), 10'(MAIN_X0), {640{1'b1}}};
      r_mask      <= 16'd0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_tick_d1 <= bus.refresh_tick;
      r_tick_d2 <= r_tick_d1;
      if (bus.start) begin
        r_state     <= S_RUN;
        r_idx       <= 5'd0;
        r_frame_cnt <= 8'd0;
        r_position  <= w_init_pos;
        r_mask      <= 16'h0001;
        r_busy      <= 1'b0;
        r_overrun   <= 1'b0;
      end else begin
        case (r_state)
          S_RUN: begin
            if (w_tick_edge) begin
              if (bus.status) r_state <= S_OVER;
              else begin
                r_state <= S_UPDATE;
                r_idx   <= 5'd0;
                r_busy  <= 1'b1;
              end
            end
          end
          S_UPDATE: begin
            if (w_tick_edge) r_overrun <= 1'b1;
            if (w_commit) begin
              r_state     <= S_RUN;
              r_busy      <= 1'b0;
              r_position  <= w_commit_pos;
              r_mask      <= w_nmask;
              r_frame_cnt <= (r_frame_cnt == 8'(SPAWN_FRAMES - 1)) ? 8'd0 : r_frame_cnt + 8'd1;
            end else begin
              r_idx <= r_idx + 5'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.position    = r_position;
  assign bus.active_mask = r_mask;
  assign bus.busy        = r_busy;
  assign bus.overrun     = r_overrun;
endmodule
